// File: rtl/ibex_custom_ctrl_pkg.sv
// Shared types for the custom (bloom) unit sequencer.
// Holds the controller state encoding and the latched request bundle.
package ibex_custom_ctrl_pkg;

    localparam int unsigned CustomOpW = 5;
    localparam int unsigned XlenW     = 32;

    typedef enum logic [2:0] {
        CTRL_IDLE,
        CTRL_ISSUE,
        CTRL_WAIT,
        CTRL_DONE,
        CTRL_DRAIN
    } custom_ctrl_state_e;

    typedef struct packed {
        logic [CustomOpW-1:0] op;
        logic [XlenW-1:0]     rs1;
        logic [XlenW-1:0]     rs2;
    } custom_req_t;

    function automatic logic op_legal(
        input logic [31:0]          mask,
        input logic [CustomOpW-1:0] op
    );
        return mask[op];
    endfunction

endpackage

// File: rtl/ibex_custom_ctrl_if.sv
// Request, custom-unit and response signals of the sequencer.
// master drives ID/EX and unit side; slave is the controller.
interface ibex_custom_ctrl_if;
    import ibex_custom_ctrl_pkg::*;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [CustomOpW-1:0] req_op_i;
    logic [XlenW-1:0]     req_rs1_i;
    logic [XlenW-1:0]     req_rs2_i;
    logic                 flush_i;

    logic                 cu_en_o;
    logic [CustomOpW-1:0] cu_op_o;
    logic [XlenW-1:0]     cu_rs1_o;
    logic [XlenW-1:0]     cu_rs2_o;
    logic                 cu_valid_i;
    logic [XlenW-1:0]     cu_result_i;

    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [XlenW-1:0]     rsp_result_o;
    logic                 rsp_err_o;
    logic                 busy_o;

    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i,
        output flush_i, cu_valid_i, cu_result_i, rsp_ready_i,
        input  req_ready_o, cu_en_o, cu_op_o, cu_rs1_o, cu_rs2_o,
        input  rsp_valid_o, rsp_result_o, rsp_err_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i,
        input  flush_i, cu_valid_i, cu_result_i, rsp_ready_i,
        output req_ready_o, cu_en_o, cu_op_o, cu_rs1_o, cu_rs2_o,
        output rsp_valid_o, rsp_result_o, rsp_err_o, busy_o
    );

endinterface

// File: rtl/ibex_custom_ctrl.sv
// Sequencer between ID/EX and the multi-cycle custom unit.
// One op in flight; timeout, flush drain and held response.
module ibex_custom_ctrl
    import ibex_custom_ctrl_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16,
    parameter logic [31:0] OpValidMask   = 32'hFFFF_FFFF
) (
    input logic               clk_i,
    input logic               rst_ni,
    ibex_custom_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    custom_ctrl_state_e state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
    custom_req_t        req_q, req_d;
    logic [XlenW-1:0]   res_q, res_d;
    logic               err_q, err_d;
    logic               timeout;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    assign timeout = (cnt_q == CntLast);

    // Next state, counter, operand latch and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            CTRL_IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    req_d.op  = bus.req_op_i;
                    req_d.rs1 = bus.req_rs1_i;
                    req_d.rs2 = bus.req_rs2_i;
                    res_d     = '0;
                    if (op_legal(OpValidMask, bus.req_op_i)) begin
                        err_d   = 1'b0;
                        state_d = CTRL_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = CTRL_DONE;
                    end
                end
            end
            CTRL_ISSUE: begin
                cnt_d   = '0;
                state_d = bus.flush_i ? CTRL_DRAIN : CTRL_WAIT;
            end
            CTRL_WAIT: begin
                if (bus.flush_i) begin
                    cnt_d   = cnt_inc;
                    state_d = CTRL_DRAIN;
                end else if (bus.cu_valid_i) begin
                    res_d   = bus.cu_result_i;
                    err_d   = 1'b0;
                    state_d = CTRL_DONE;
                end else if (timeout) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = CTRL_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CTRL_DONE: begin
                if (bus.rsp_ready_i || bus.flush_i) begin
                    state_d = CTRL_IDLE;
                end
            end
            CTRL_DRAIN: begin
                if (bus.cu_valid_i || timeout) begin
                    state_d = CTRL_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    // State, counter, operand and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_o  = (state_q == CTRL_IDLE);
    assign bus.busy_o       = (state_q != CTRL_IDLE);
    assign bus.cu_en_o      = (state_q == CTRL_ISSUE);
    assign bus.cu_op_o      = req_q.op;
    assign bus.cu_rs1_o     = req_q.rs1;
    assign bus.cu_rs2_o     = req_q.rs2;
    assign bus.rsp_valid_o  = (state_q == CTRL_DONE);
    assign bus.rsp_result_o = bus.rsp_valid_o ? res_q : '0;
    assign bus.rsp_err_o    = bus.rsp_valid_o & err_q;

    a_en_pulse: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.cu_en_o |=> !bus.cu_en_o
    );

    a_rsp_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.rsp_valid_o && !bus.rsp_ready_i && !bus.flush_i
        |=> bus.rsp_valid_o
            && $stable(bus.rsp_result_o)
            && $stable(bus.rsp_err_o)
    );

    c_spurious_valid: cover property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.cu_valid_i
        && (state_q inside {CTRL_IDLE, CTRL_ISSUE, CTRL_DONE})
    );

endmodule

// File: tb/tb_ibex_custom_ctrl.sv
// Bench for ibex_custom_ctrl: random ops against a timing model.
// Unit model answers with a chosen latency; a monitor scores responses.
module tb_ibex_custom_ctrl;

    localparam int          T    = 16;
    localparam logic [31:0] MASK = 32'hEFFF_FF7F;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
        bit          discard;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    exp_t sb[$];

    int          lat_cfg;
    logic [31:0] res_cfg;
    bit          unit_pend;
    int          unit_fire;
    logic [31:0] unit_res;

    ibex_custom_ctrl_if bus ();

    ibex_custom_ctrl #(
        .TimeoutCycles (T),
        .OpValidMask   (MASK)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // One clock; the unit model sees cu_en in ISSUE and fires L cycles later.
    task automatic tick();
        if (bus.cu_en_o && rst_n) begin
            unit_pend = (lat_cfg != 0);
            unit_fire = cyc + lat_cfg;
            unit_res  = res_cfg;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (unit_pend && cyc == unit_fire) begin
            bus.cu_valid_i  = 1'b1;
            bus.cu_result_i = unit_res;
            unit_pend       = 1'b0;
        end else begin
            bus.cu_valid_i  = 1'b0;
            bus.cu_result_i = $urandom;
        end
    endtask

    task automatic wait_idle(input int exp_cyc);
        int n;
        n = 0;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 5'd1;
        while (!bus.req_ready_o && n < 100) begin
            tick();
            n++;
        end
        bus.req_valid_i = 1'b0;
        chk("drain_exit_cycle", cyc, exp_cyc);
    endtask

    // fmode: 0 none, 1 flush in ISSUE, 2 flush in WAIT at +fd, 3 flush in DONE
    task automatic run_op(
        input logic [4:0]  op,
        input logic [31:0] rs1,
        input logic [31:0] rs2,
        input logic [31:0] res,
        input int          lat,
        input int          hold,
        input int          fmode,
        input int          fd
    );
        int   n, a, eff, dn, md, d;
        logic legal;
        exp_t e;
        legal = MASK[op];
        md    = fmode;
        eff   = (lat == 0) ? T + 1 : lat;
        if (!legal && (md == 1 || md == 2)) md = 0;
        if (md == 2 && eff < 2) md = 0;
        n = 0;
        while ((unit_pend || !bus.req_ready_o) && n < 200) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 200), 32'd1);
        lat_cfg         = lat;
        res_cfg         = res;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_rs1_i   = rs1;
        bus.req_rs2_i   = rs2;
        tick();
        a               = cyc - 1;
        bus.req_valid_i = 1'b0;
        bus.req_rs1_i   = $urandom;
        bus.req_rs2_i   = $urandom;
        chk("cu_op", bus.cu_op_o, op);
        chk("cu_rs1", bus.cu_rs1_o, rs1);
        chk("cu_rs2", bus.cu_rs2_o, rs2);
        chk("cu_en", bus.cu_en_o, legal);
        dn = legal ? a + 2 + min2(eff, T) : a + 1;
        if (legal) begin
            if (md == 1) bus.flush_i = 1'b1;
            tick();
            bus.flush_i = 1'b0;
            chk("cu_en_pulse", bus.cu_en_o, 0);
            if (md == 1) begin
                wait_idle(dn);
                return;
            end
            if (md == 2) begin
                d = fd % min2(eff - 1, T - 1);
                repeat (d) tick();
                bus.flush_i = 1'b1;
                tick();
                bus.flush_i = 1'b0;
                wait_idle(dn);
                return;
            end
        end
        e.err     = !legal || (eff > T);
        e.res     = e.err ? 32'd0 : res;
        e.cyc     = dn;
        e.discard = (md == 3);
        sb.push_back(e);
        n = 0;
        while (!bus.rsp_valid_o && n < 60) begin
            tick();
            n++;
        end
        chk("rsp_wait", 32'(n < 60), 32'd1);
        repeat (hold) tick();
        if (md == 3) begin
            bus.flush_i = 1'b1;
            tick();
            bus.flush_i = 1'b0;
            tick();
            chk("done_flush_idle", bus.busy_o, 0);
        end else begin
            bus.rsp_ready_i = 1'b1;
            tick();
            bus.rsp_ready_i = 1'b0;
        end
    endtask

    // Scoreboard monitor: checks every response window against the queue.
    initial begin
        bit          in_rsp;
        bit          ghost;
        exp_t        cur;
        logic [31:0] h_res;
        logic        h_err;
        in_rsp = 0;
        ghost  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0;
                ghost  = 0;
            end else if (bus.rsp_valid_o) begin
                if (!in_rsp) begin
                    in_rsp = 1;
                    h_res  = bus.rsp_result_o;
                    h_err  = bus.rsp_err_o;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        ghost = 1;
                        cur.discard = 1;
                        $display("FAIL unexpected_rsp: got res %0h err %0b want none",
                                 h_res, h_err);
                    end else begin
                        cur = sb[0];
                        chk("rsp_cycle", cyc, cur.cyc);
                        chk("rsp_result", h_res, cur.res);
                        chk("rsp_err", h_err, cur.err);
                    end
                end else begin
                    chk("rsp_hold_res", bus.rsp_result_o, h_res);
                    chk("rsp_hold_err", bus.rsp_err_o, h_err);
                    chk("req_ready_done", bus.req_ready_o, 0);
                end
                if (bus.rsp_ready_i) begin
                    chk("rsp_accepted_ok", 32'(cur.discard), 0);
                    if (!ghost) void'(sb.pop_front());
                    in_rsp = 0;
                    ghost  = 0;
                end
            end else if (in_rsp) begin
                chk("rsp_discarded_ok", 32'(cur.discard), 1);
                if (!ghost) void'(sb.pop_front());
                in_rsp = 0;
                ghost  = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        unit_pend = 0;
        unit_fire = 0;
        unit_res  = 0;
        lat_cfg   = 0;
        res_cfg   = 0;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = '0;
        bus.req_rs1_i   = '0;
        bus.req_rs2_i   = '0;
        bus.flush_i     = 1'b0;
        bus.cu_valid_i  = 1'b0;
        bus.cu_result_i = '0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_cu_en", bus.cu_en_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_err", bus.rsp_err_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_cu_rs1", bus.cu_rs1_o, 0);
        rst_n = 1'b1;
        tick();

        run_op(5'd3, 32'hA5A5_0001, 32'd7, 32'h1, 3, 0, 0, 0);
        run_op(5'd28, 32'h1234, 32'h5678, 32'hDEAD, 2, 0, 0, 0);
        run_op(5'd4, 32'h11, 32'h22, 32'hBEEF, 0, 0, 0, 0);
        run_op(5'd6, 32'h33, 32'h44, 32'hCAFE_F00D, 2, 10, 0, 0);
        run_op(5'd9, 32'h55, 32'h66, 32'h77, 5, 0, 2, 0);
        run_op(5'd9, 32'h88, 32'h99, 32'h1357, 4, 0, 0, 0);
        run_op(5'd10, 32'h1, 32'h2, 32'h3, 1, 0, 1, 0);
        run_op(5'd11, 32'h4, 32'h5, 32'h6, 2, 2, 3, 0);

        bus.req_valid_i = 1'b1;
        bus.flush_i     = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        chk("flush_idle_ignored", bus.busy_o, 0);

        lat_cfg         = 8;
        res_cfg         = 32'hFEED;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 5'd5;
        bus.req_rs1_i   = 32'hABCD;
        tick();
        a = cyc - 1;
        bus.req_valid_i = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_cu_en", bus.cu_en_o, 0);
        chk("arst_rsp_valid", bus.rsp_valid_o, 0);
        chk("arst_cu_rs1", bus.cu_rs1_o, 0);
        chk("arst_req_ready", bus.req_ready_o, 1);
        sb.delete();
        tick();
        rst_n = 1'b1;
        while (unit_pend && cyc < a + 40) tick();
        tick();
        chk("stale_ignored", bus.busy_o, 0);
        run_op(5'd5, 32'h2468, 32'h1357, 32'h600D, 2, 1, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int r, lat, md;
            r = $urandom_range(0, 9);
            if (r == 0) lat = 0;
            else if (r == 1) lat = $urandom_range(T + 1, T + 4);
            else lat = $urandom_range(1, T);
            r = $urandom_range(0, 9);
            md = (r < 3) ? r + 1 : 0;
            run_op(5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
                   lat, $urandom_range(0, 3), md, $urandom_range(0, 15));
        end
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
